// File: rtl/nx_fifo_1r1w_hw_sched_if.sv
// Handshake, status and RAM-port bundle for nx_fifo_1r1w_hw_sched.
// slave is the FIFO side; master is the producer/consumer/RAM side.
interface nx_fifo_1r1w_hw_sched_if #(
    parameter int N_DATA_BITS = 32,
    parameter int N_ENTRIES   = 16,
    parameter int RD_LAT      = 2
);
    localparam int CAP = N_ENTRIES + RD_LAT + 1;
    localparam int CW  = $clog2(CAP + 1);
    localparam int AW  = $clog2(N_ENTRIES);

    logic                   flush;
    logic                   wr_vld;
    logic                   wr_rdy;
    logic [N_DATA_BITS-1:0] wr_dat;
    logic                   rd_vld;
    logic                   rd_rdy;
    logic [N_DATA_BITS-1:0] rd_dat;
    logic [CW-1:0]          fifo_count;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   hw_cs;
    logic [AW-1:0]          hw_waddr;
    logic [AW-1:0]          hw_raddr;
    logic                   hw_we;
    logic                   hw_re;
    logic [N_DATA_BITS-1:0] hw_din;
    logic [N_DATA_BITS-1:0] hw_dout;
    logic                   hw_yield;
    logic                   starve_force;

    modport slave (
        input  flush, wr_vld, wr_dat, rd_rdy, hw_dout, hw_yield,
        output wr_rdy, rd_vld, rd_dat, fifo_count, fifo_empty,
        output fifo_full, hw_cs, hw_waddr, hw_raddr, hw_we,
        output hw_re, hw_din, starve_force
    );

    modport master (
        output flush, wr_vld, wr_dat, rd_rdy, hw_dout, hw_yield,
        input  wr_rdy, rd_vld, rd_dat, fifo_count, fifo_empty,
        input  fifo_full, hw_cs, hw_waddr, hw_raddr, hw_we,
        input  hw_re, hw_din, starve_force
    );
endinterface

// File: rtl/nx_fifo_1r1w_hw_sched.sv
// FIFO over an external 1R1W RAM shared with a debug port; hardware
// yields to software but forces one access after YIELD_MAX blocked cycles.
module nx_fifo_1r1w_hw_sched #(
    parameter int N_DATA_BITS = 32,
    parameter int N_ENTRIES   = 16,
    parameter int RD_LAT      = 2,
    parameter int YIELD_MAX   = 8
) (
    input logic clk,
    input logic rst_n,
    nx_fifo_1r1w_hw_sched_if.slave bus
);
    localparam int CAP = N_ENTRIES + RD_LAT + 1;
    localparam int CW  = $clog2(CAP + 1);
    localparam int AW  = $clog2(N_ENTRIES);
    localparam int MW  = $clog2(N_ENTRIES + 1);
    localparam int BUF = RD_LAT + 1;
    localparam int BW  = $clog2(BUF + 1);
    localparam int YW  = $clog2(YIELD_MAX + 1);

    typedef enum logic [1:0] {RUN, YIELD, FORCE} state_e;

    state_e                 state_q, state_d;
    logic [YW-1:0]          ycnt_q, ycnt_d;
    logic [AW-1:0]          wptr_q, wptr_d;
    logic [AW-1:0]          rptr_q, rptr_d;
    logic [MW-1:0]          mem_cnt_q, mem_cnt_d;
    logic [RD_LAT-1:0]      infl_q, infl_d;
    logic [BW-1:0]          bcnt_q, bcnt_d;
    logic [N_DATA_BITS-1:0] buf_q [BUF];
    logic [N_DATA_BITS-1:0] buf_d [BUF];

    logic          access, wr_rdy, rd_elig, work;
    logic          issue_wr, issue_rd, hw_cs;
    logic          pop, land;
    logic [BW-1:0] infl_cnt, bidx;
    logic [BW:0]   occ;
    logic [YW:0]   ycnt_inc;
    logic [CW-1:0] count;

    always_comb begin
        infl_cnt = '0;
        for (int i = 0; i < RD_LAT; i++)
            infl_cnt = infl_cnt + BW'(infl_q[i]);
    end

    assign land = infl_q[RD_LAT-1];
    assign pop  = (bcnt_q != '0) & bus.rd_rdy & ~bus.flush;
    assign bidx = bcnt_q - BW'(pop);

    // A pop this cycle frees a slot, so streaming never stalls.
    assign occ = {1'b0, infl_cnt} + {1'b0, bcnt_q} - (BW+1)'(pop);

    assign access = rst_n & ~bus.flush &
                    ((state_q == FORCE) | ~bus.hw_yield);

    assign rd_elig  = (mem_cnt_q != '0) & (occ < (BW+1)'(BUF));
    assign work     = bus.wr_vld | rd_elig;
    assign wr_rdy   = access & (mem_cnt_q < MW'(N_ENTRIES));
    assign issue_wr = bus.wr_vld & wr_rdy;
    assign issue_rd = access & rd_elig;
    assign hw_cs    = issue_wr | issue_rd;

    assign count = CW'(mem_cnt_q) + CW'(infl_cnt) + CW'(bcnt_q);

    assign bus.wr_rdy       = wr_rdy;
    assign bus.rd_vld       = (bcnt_q != '0);
    assign bus.rd_dat       = buf_q[0];
    assign bus.fifo_count   = count;
    assign bus.fifo_empty   = (count == '0);
    assign bus.fifo_full    = (count == CW'(CAP));
    assign bus.hw_cs        = hw_cs;
    assign bus.hw_we        = issue_wr;
    assign bus.hw_re        = issue_rd;
    assign bus.hw_waddr     = wptr_q;
    assign bus.hw_raddr     = rptr_q;
    assign bus.hw_din       = bus.wr_dat;
    assign bus.starve_force = (state_q == FORCE) & hw_cs;

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        mem_cnt_d = mem_cnt_q + MW'(issue_wr) - MW'(issue_rd);
        infl_d    = (infl_q << 1) | RD_LAT'(issue_rd);
        bcnt_d    = bcnt_q - BW'(pop) + BW'(land);
        buf_d     = buf_q;
        if (pop)
            for (int i = 0; i < BUF - 1; i++)
                buf_d[i] = buf_q[i+1];
        for (int i = 0; i < BUF; i++)
            if (land && (BW'(i) == bidx))
                buf_d[i] = bus.hw_dout;
        if (issue_wr)
            wptr_d = (wptr_q == AW'(N_ENTRIES - 1)) ? '0 : wptr_q + AW'(1);
        if (issue_rd)
            rptr_d = (rptr_q == AW'(N_ENTRIES - 1)) ? '0 : rptr_q + AW'(1);
        // Returning reads are dropped because the valids clear with the data.
        if (bus.flush) begin
            wptr_d    = '0;
            rptr_d    = '0;
            mem_cnt_d = '0;
            infl_d    = '0;
            bcnt_d    = '0;
        end
    end

    assign ycnt_inc = {1'b0, ycnt_q} + (YW+1)'(work);

    always_comb begin
        state_d = state_q;
        ycnt_d  = ycnt_q;
        unique case (state_q)
            RUN: begin
                // The blocked RUN cycle counts toward the starvation limit.
                if (bus.hw_yield) begin
                    state_d = YIELD;
                    ycnt_d  = YW'(work);
                end
            end
            YIELD: begin
                if (!bus.hw_yield) begin
                    state_d = RUN;
                    ycnt_d  = '0;
                end else if (ycnt_inc >= (YW+1)'(YIELD_MAX)) begin
                    state_d = FORCE;
                    ycnt_d  = '0;
                end else begin
                    ycnt_d = ycnt_inc[YW-1:0];
                end
            end
            FORCE: begin
                state_d = bus.hw_yield ? YIELD : RUN;
                ycnt_d  = '0;
            end
            default: begin
                state_d = RUN;
                ycnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            ycnt_q    <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            mem_cnt_q <= '0;
            infl_q    <= '0;
            bcnt_q    <= '0;
            for (int i = 0; i < BUF; i++)
                buf_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            ycnt_q    <= ycnt_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            mem_cnt_q <= mem_cnt_d;
            infl_q    <= infl_d;
            bcnt_q    <= bcnt_d;
            buf_q     <= buf_d;
        end
    end
endmodule

// File: doc/nx_fifo_1r1w_hw_sched.md
NX_FIFO_1R1W_HW_SCHED -- requirements
Module: nx_fifo_1r1w_hw_sched

Interface
REQ-001 Parameter N_DATA_BITS, default 32: word width.
REQ-002 Parameter N_ENTRIES, default 16: RAM depth, at least 2.
REQ-003 Parameter RD_LAT, default 2: RAM read latency in cycles, from hw_re to valid hw_dout, range 1..3.
REQ-004 Parameter YIELD_MAX, default 8: maximum consecutive cycles hardware is blocked by hw_yield before it forces one access, at least 1.
REQ-005 Derived: CAP = N_ENTRIES+RD_LAT+1; CW = clog2(CAP+1).
REQ-006 The block SHALL have one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-007 Port list, in order (name, direction, width, meaning):
- clk, in, 1: clock.
- rst_n, in, 1: asynchronous active-low reset.
- flush, in, 1: synchronous clear of all FIFO contents.
- wr_vld, in, 1: push request.
- wr_rdy, out, 1: push accepted when wr_vld=1 and wr_rdy=1.
- wr_dat, in, N_DATA_BITS: push data.
- rd_vld, out, 1: head word valid.
- rd_rdy, in, 1: pop when rd_vld=1 and rd_rdy=1.
- rd_dat, out, N_DATA_BITS: head word.
- fifo_count, out, CW: total words held.
- fifo_empty, out, 1: fifo_count==0.
- fifo_full, out, 1: fifo_count==CAP.
- hw_cs, out, 1: hardware owns the RAM this cycle (the debug controller grants software when hw_cs=0).
- hw_waddr, out, clog2(N_ENTRIES): RAM write address.
- hw_raddr, out, clog2(N_ENTRIES): RAM read address.
- hw_we, out, 1: RAM write enable.
- hw_re, out, 1: RAM read enable.
- hw_din, out, N_DATA_BITS: RAM write data.
- hw_dout, in, N_DATA_BITS: RAM read data.
- hw_yield, in, 1: software access is pending.
- starve_force, out, 1: one-cycle pulse marking a forced hardware cycle.

Function
REQ-008 Storage: RAM holds mem_cnt words; an output buffer of RD_LAT+1 entries holds prefetched words. fifo_count SHALL equal mem_cnt plus in-flight reads plus buffered words.
REQ-009 Write issue: issue_wr = wr_vld & wr_rdy. The block SHALL drive hw_we=1, hw_waddr=wptr, hw_din=wr_dat. wptr SHALL increment, wrapping from N_ENTRIES-1 to 0.
REQ-010 wr_rdy SHALL be 1 only when all three hold: mem_cnt<N_ENTRIES, state allows access, and flush=0.
REQ-011 Read issue SHALL occur only when all three hold: mem_cnt>0 (registered value), in-flight plus buffered < RD_LAT+1, and state allows access. On issue: hw_re=1, hw_raddr=rptr, rptr increments with wrap.
REQ-012 A write and a read in the same cycle are both permitted. A write in cycle N SHALL NOT be read before cycle N+1.
REQ-013 A read issued in cycle N SHALL load hw_dout into the output buffer in cycle N+RD_LAT. A valid shift register of length RD_LAT SHALL track in-flight reads.
REQ-014 rd_vld SHALL be 1 when the buffer is non-empty; rd_dat SHALL be the oldest buffered word. Order SHALL be strict FIFO.
REQ-015 hw_cs SHALL equal issue_wr | issue_rd. The block SHALL never assert hw_cs without hw_we or hw_re.
REQ-016 The arbitration FSM SHALL have three states:
- RUN: access allowed.
- YIELD: access blocked; a starvation counter of width clog2(YIELD_MAX+1) runs.
- FORCE: access allowed for exactly one cycle.
REQ-017 FSM transitions:
- RUN to YIELD when hw_yield=1; the blocking applies in that same cycle, so RUN grants access only when hw_yield=0.
- YIELD to RUN when hw_yield=0.
- In YIELD, the counter SHALL increment each cycle that hardware has work (wr_vld, or a read is eligible). At YIELD_MAX the FSM SHALL move to FORCE.
- FORCE to YIELD if hw_yield=1, else to RUN. The counter SHALL clear on leaving YIELD.
REQ-018 starve_force SHALL be 1 during FORCE only if a hardware access is issued in that cycle.
REQ-019 Flush: in the cycle flush=1, no access SHALL be issued. On the next edge wptr, rptr, mem_cnt, the buffer and the in-flight valids SHALL clear. Read data still in flight SHALL be discarded. The FSM state SHALL be unaffected.
REQ-020 A pop concurrent with flush SHALL be ignored. fifo_count SHALL read 0 in the cycle after flush.
REQ-021 Counters SHALL never wrap: push at full and pop at empty cannot occur through the handshake.

Reset
REQ-022 On rst_n=0, asynchronously:
- Pointers, counts, buffer valids, in-flight valids and the starvation counter SHALL be 0.
- The FSM SHALL be in RUN.
- wr_rdy=0, rd_vld=0, hw_cs=0, hw_we=0, hw_re=0, starve_force=0, fifo_empty=1, fifo_full=0.
REQ-023 wr_rdy SHALL rise in the first cycle after reset deasserts.
REQ-024 Reset mid-operation SHALL drop all contents without emitting any partial pop.

Verification
REQ-025 Defaults, 20 pushes with no pops: wr_rdy falls after word 19, fifo_count=19, fifo_full=1. Pops then return words 0..18 in order.
REQ-026 Continuous push and pop with rd_rdy=1: after fill, one word per cycle. The RAM sees hw_we and hw_re in the same cycle, and throughput never drops.
REQ-027 hw_yield held at 1 with wr_vld=1: hw_cs=0 for 8 cycles, then a single FORCE cycle with starve_force=1 and one write, repeating every 9 cycles.
REQ-028 hw_yield pulsed for 1 cycle: hw_cs=0 in that cycle only, and no data is lost.
REQ-029 Flush with 2 reads in flight: the next cycle shows fifo_count=0 and rd_vld=0, and returning data never appears on rd_dat.
REQ-030 rst_n asserted with 5 words stored: all outputs take reset values immediately, and after release fifo_empty=1.
